// File: rtl/quat_attitude_seq_if.sv
// Sample-in / attitude-out bundle of quat_attitude_seq.
// The master drives the gyro samples and q_clear; the slave returns the quaternion and status.
interface quat_attitude_seq_if #(
  parameter int DT_W = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic signed [15:0]     wx;
  logic signed [15:0]     wy;
  logic signed [15:0]     wz;
  logic        [DT_W-1:0] dt;
  logic                   q_clear;
  logic                   busy;
  logic signed [15:0]     q0;
  logic signed [15:0]     q1;
  logic signed [15:0]     q2;
  logic signed [15:0]     q3;
  logic                   q_valid;

  modport master (
    output s_valid, wx, wy, wz, dt, q_clear,
    input  s_ready, busy, q0, q1, q2, q3, q_valid
  );

  modport slave (
    input  s_valid, wx, wy, wz, dt, q_clear,
    output s_ready, busy, q0, q1, q2, q3, q_valid
  );
endinterface

// File: rtl/quat_attitude_seq.sv
// Attitude integrator q := q (x) dq, one Hamilton product per gyro sample on a single shared MAC.
// Optional renormalisation after the product is compiled in with the macro QUAT_RENORM_EN.
module quat_attitude_seq #(
  parameter int DT_W     = 16,
  parameter int DT_SHIFT = 16,
  parameter int ACC_W    = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  quat_attitude_seq_if.slave    bus
);

`ifdef QUAT_RENORM_EN
  localparam int MW = 18;
`else
  localparam int MW = 16;
`endif
  localparam int PW = 2 * MW;
  localparam int DW = 16 + DT_W + 1;
  // Bit k set where term k of the Hamilton product is subtracted.
  localparam logic [15:0] NEG_MASK = 16'h428E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELTA,
    S_MUL,
`ifdef QUAT_RENORM_EN
    S_RN_NORM,
    S_RN_SCALE,
`endif
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_s_ready;
  logic                     w_busy;
  logic [3:0]               r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [15:0]       r_q [4];
  logic signed [15:0]       r_dq [4];
  logic signed [15:0]       r_r [4];
  logic signed [15:0]       r_w [3];
  logic        [DT_W-1:0]   r_dt;
  logic                     r_q_valid;
  logic signed [DW-1:0]     w_dte;
  logic signed [DW-1:0]     w_wp [3];
  logic signed [MW-1:0]     w_ma;
  logic signed [MW-1:0]     w_mb;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [15:0]       w_ri;
`ifdef QUAT_RENORM_EN
  logic signed [17:0]       r_s;
  logic signed [15:0]       r_n [4];
  logic        [17:0]       w_n2;
  logic signed [15:0]       w_sc;
`endif

  function automatic logic signed [15:0] sat16(input logic signed [63:0] x);
    if (x > 64'sd32767)       return 16'sd32767;
    else if (x < -64'sd32767) return -16'sd32767;
    else                      return x[15:0];
  endfunction

  assign w_dte = signed'(DW'(r_dt));
  always_comb begin
    for (int i = 0; i < 3; i++) w_wp[i] = DW'(r_w[i]) * w_dte;
  end

  // Shared multiplier: operand selection per state and MAC index.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_MUL: begin
        w_ma = MW'(r_q[r_k[1:0]]);
        w_mb = MW'(r_dq[r_k[3:2] ^ r_k[1:0]]);
      end
`ifdef QUAT_RENORM_EN
      S_RN_NORM: begin
        w_ma = MW'(r_r[r_k[1:0]]);
        w_mb = MW'(r_r[r_k[1:0]]);
      end
      S_RN_SCALE: begin
        w_ma = MW'(r_r[r_k[1:0]]);
        w_mb = r_s;
      end
`endif
      default: ;
    endcase
  end

  assign w_prod = PW'(w_ma) * PW'(w_mb);
  assign w_term = ACC_W'(w_prod);
  assign w_sum  = ((r_state == S_MUL) && NEG_MASK[r_k]) ? r_acc - w_term : r_acc + w_term;
  assign w_ri   = sat16(64'(w_sum >>> 15));
`ifdef QUAT_RENORM_EN
  assign w_n2   = 18'(w_sum >>> 15);
  assign w_sc   = sat16(64'(w_prod >>> 15));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy    = 1'b0;
        w_s_ready = !bus.q_clear;
        if (!bus.q_clear && bus.s_valid) w_next = S_DELTA;
      end
      S_DELTA: w_next = S_MUL;
`ifdef QUAT_RENORM_EN
      S_MUL:      if (r_k == 4'd15) w_next = S_RN_NORM;
      S_RN_NORM:  if (r_k == 4'd3)  w_next = S_RN_SCALE;
      S_RN_SCALE: if (r_k == 4'd3)  w_next = S_DONE;
`else
      S_MUL:      if (r_k == 4'd15) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
      r_acc     <= '0;
      r_k       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.q_clear) begin
            r_q       <= '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
            r_q_valid <= 1'b1;
          end else if (bus.s_valid) begin
            r_w  <= '{bus.wx, bus.wy, bus.wz};
            r_dt <= bus.dt;
          end
        end
        S_DELTA: begin
          r_dq[0] <= 16'sd32767;
          for (int i = 0; i < 3; i++) r_dq[i+1] <= sat16(64'(w_wp[i] >>> DT_SHIFT));
          r_k <= '0;
        end
        S_MUL: begin
          r_k <= r_k + 4'd1;
          if (r_k[1:0] == 2'd3) begin
            r_r[r_k[3:2]] <= w_ri;
            r_acc         <= '0;
          end else begin
            r_acc <= w_sum;
          end
`ifndef QUAT_RENORM_EN
          if (r_k == 4'd15) r_q <= '{r_r[0], r_r[1], r_r[2], w_ri};
`endif
        end
`ifdef QUAT_RENORM_EN
        // n2 = sum r_i^2 >>> 15, then s = 1.5 - n2/2 in Q1.15.
        S_RN_NORM: begin
          if (r_k == 4'd3) begin
            r_k   <= '0;
            r_acc <= '0;
            r_s   <= 18'sd49152 - signed'(w_n2 >> 1);
          end else begin
            r_k   <= r_k + 4'd1;
            r_acc <= w_sum;
          end
        end
        S_RN_SCALE: begin
          r_n[r_k[1:0]] <= w_sc;
          if (r_k == 4'd3) begin
            r_k <= '0;
            r_q <= '{r_n[0], r_n[1], r_n[2], w_sc};
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.busy    = w_busy;
  assign bus.q0      = r_q[0];
  assign bus.q1      = r_q[1];
  assign bus.q2      = r_q[2];
  assign bus.q3      = r_q[3];
  assign bus.q_valid = r_q_valid;

endmodule

// File: tb/tb_quat_attitude_seq.sv
// Bench for quat_attitude_seq: a DT_SHIFT=16 and a DT_SHIFT=8 instance share one stimulus
// stream and are compared every cycle against a quaternion-level reference model.
module tb_quat_attitude_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef QUAT_RENORM_EN
  localparam int BUSY = 26;
`else
  localparam int BUSY = 18;
`endif
  // Cycles from the accepting edge to the cycle in which q_valid is high.
  localparam int QV = BUSY - 1;

  quat_attitude_seq_if #(.DT_W(16)) u_if ();
  quat_attitude_seq_if #(.DT_W(16)) u_if8 ();

  assign u_if8.s_valid = u_if.s_valid;
  assign u_if8.wx      = u_if.wx;
  assign u_if8.wy      = u_if.wy;
  assign u_if8.wz      = u_if.wz;
  assign u_if8.dt      = u_if.dt;
  assign u_if8.q_clear = u_if.q_clear;

  quat_attitude_seq #(.DT_W(16), .DT_SHIFT(16), .ACC_W(36)) u_dut (
    .clk (clk), .rst (rst), .bus (u_if.slave));
  quat_attitude_seq #(.DT_W(16), .DT_SHIFT(8), .ACC_W(36)) u_dut8 (
    .clk (clk), .rst (rst), .bus (u_if8.slave));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input integer act, input integer exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32767) return -32767;
    return int'(x);
  endfunction

  // q (x) dq with dq = (1, w*dt) in Q1.15, optionally renormalised.
  function automatic void calc(input int sh, input int a[4], input int wx, input int wy,
                               input int wz, input int dt, output int r[4]);
    longint A[4];
    longint b[4];
    longint s[4];
    int     w[3];
    w = '{wx, wy, wz};
    for (int i = 0; i < 4; i++) A[i] = longint'(a[i]);
    b[0] = 32767;
    for (int i = 0; i < 3; i++) b[i+1] = sat16((longint'(w[i]) * longint'(dt)) >>> sh);
    s[0] = A[0]*b[0] - A[1]*b[1] - A[2]*b[2] - A[3]*b[3];
    s[1] = A[0]*b[1] + A[1]*b[0] + A[2]*b[3] - A[3]*b[2];
    s[2] = A[0]*b[2] - A[1]*b[3] + A[2]*b[0] + A[3]*b[1];
    s[3] = A[0]*b[3] + A[1]*b[2] - A[2]*b[1] + A[3]*b[0];
    for (int i = 0; i < 4; i++) r[i] = sat16(s[i] >>> 15);
`ifdef QUAT_RENORM_EN
    begin
      longint n2, sc;
      n2 = 0;
      for (int i = 0; i < 4; i++) n2 += longint'(r[i]) * longint'(r[i]);
      n2 = n2 >>> 15;
      sc = 49152 - (n2 >>> 1);
      for (int i = 0; i < 4; i++) r[i] = sat16((longint'(r[i]) * sc) >>> 15);
    end
`endif
  endfunction

  int mq[2][4];
  int mnext[2][4];
  int mcnt[2];
  bit mvld[2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        mq[u] = '{32767, 0, 0, 0};
        mcnt[u] = 0;
        mvld[u] = 1'b0;
      end else if (mcnt[u] == 0) begin
        mvld[u] = 1'b0;
        if (u_if.q_clear) begin
          mq[u] = '{32767, 0, 0, 0};
          mvld[u] = 1'b1;
        end else if (u_if.s_valid) begin
          int a[4];
          int r[4];
          a = mq[u];
          calc((u == 0) ? 16 : 8, a, int'(u_if.wx), int'(u_if.wy), int'(u_if.wz),
               int'(u_if.dt), r);
          mnext[u] = r;
          mcnt[u] = BUSY;
        end
      end else begin
        mcnt[u]--;
        mvld[u] = 1'b0;
        if (mcnt[u] == 1) begin
          mq[u] = mnext[u];
          mvld[u] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        integer act[7];
        integer exp[7];
        string  pre;
        pre = (u == 0) ? "sh16" : "sh8";
        if (u == 0) act = '{u_if.q0, u_if.q1, u_if.q2, u_if.q3,
                            u_if.q_valid, u_if.busy, u_if.s_ready};
        else        act = '{u_if8.q0, u_if8.q1, u_if8.q2, u_if8.q3,
                            u_if8.q_valid, u_if8.busy, u_if8.s_ready};
        exp = '{mq[u][0], mq[u][1], mq[u][2], mq[u][3], integer'(mvld[u]),
                integer'(mcnt[u] != 0), integer'((mcnt[u] == 0) && !u_if.q_clear)};
        chk({pre, ".q0"}, act[0], exp[0]);
        chk({pre, ".q1"}, act[1], exp[1]);
        chk({pre, ".q2"}, act[2], exp[2]);
        chk({pre, ".q3"}, act[3], exp[3]);
        chk({pre, ".q_valid"}, act[4], exp[4]);
        chk({pre, ".busy"}, act[5], exp[5]);
        chk({pre, ".s_ready"}, act[6], exp[6]);
      end
    end
  end

  task automatic send(input int wx, input int wy, input int wz, input int dt);
    @(negedge clk);
    u_if.s_valid = 1'b1;
    u_if.wx = 16'(wx);
    u_if.wy = 16'(wy);
    u_if.wz = 16'(wz);
    u_if.dt = 16'(dt);
    @(negedge clk);
    u_if.s_valid = 1'b0;
  endtask

  task automatic wait_qv(input string nm, input int exp_cyc);
    int n;
    n = 0;
    while (u_if.q_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, exp_cyc);
  endtask

  task automatic clear_q();
    @(negedge clk);
    u_if.q_clear = 1'b1;
    @(negedge clk);
    u_if.q_clear = 1'b0;
    chk("clear_pulse", u_if.q_valid, 1);
    chk("clear_q0", u_if.q0, 32767);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_q0"}, u_if.q0, 32767);
    chk({nm, "_q1"}, u_if.q1, 0);
    chk({nm, "_q2"}, u_if.q2, 0);
    chk({nm, "_q3"}, u_if.q3, 0);
    chk({nm, "_qvalid"}, u_if.q_valid, 0);
    chk({nm, "_busy"}, u_if.busy, 0);
    chk({nm, "_sready"}, u_if.s_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p1, p2, n;
    rst = 1'b1;
    u_if.s_valid = 1'b0;
    u_if.q_clear = 1'b0;
    u_if.wx = '0;
    u_if.wy = '0;
    u_if.wz = '0;
    u_if.dt = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk_reset_state("reset");

    // Zero rate from identity.
    send(0, 0, 0, 6554);
    wait_qv("lat_zero", QV);
`ifdef QUAT_RENORM_EN
    chk("zero_q0", u_if.q0, 32767);
`else
    chk("zero_q0", u_if.q0, 32766);
`endif
    chk("zero_q1", u_if.q1, 0);

`ifndef QUAT_RENORM_EN
    clear_q();
    send(1000, 0, 0, 6554);
    wait_qv("lat_roll_pos", QV);
    chk("roll_pos_q0", u_if.q0, 32766);
    chk("roll_pos_q1", u_if.q1, 99);
    clear_q();
    send(-1000, 0, 0, 6554);
    wait_qv("lat_roll_neg", QV);
    chk("roll_neg_q0", u_if.q0, 32766);
    chk("roll_neg_q1", u_if.q1, -101);
`endif

    // q_clear and s_valid together in IDLE: clear wins, sample taken next cycle.
    @(negedge clk);
    u_if.q_clear = 1'b1;
    u_if.s_valid = 1'b1;
    u_if.wx = 16'sd500;
    u_if.wy = -16'sd250;
    u_if.wz = 16'sd125;
    u_if.dt = 16'd9000;
    @(negedge clk);
    u_if.q_clear = 1'b0;
    chk("clr_sv_pulse", u_if.q_valid, 1);
    chk("clr_sv_not_taken", u_if.busy, 0);
    @(negedge clk);
    u_if.s_valid = 1'b0;
    chk("clr_sv_taken_next", u_if.busy, 1);
    wait_qv("lat_after_clear", QV);

    // q_clear while busy is ignored.
    send(200, -300, 400, 30000);
    repeat (5) @(negedge clk);
    u_if.q_clear = 1'b1;
    repeat (3) @(negedge clk);
    u_if.q_clear = 1'b0;
    wait_qv("lat_clear_busy", QV - 8);

    // s_valid held high: one acceptance per BUSY+1 cycles.
    p1 = -1;
    p2 = -1;
    for (int c = 0; c < 3 * BUSY + 5; c++) begin
      @(negedge clk);
      u_if.s_valid = 1'b1;
      u_if.wx = 16'($urandom_range(0, 4000)) - 16'sd2000;
      u_if.wy = 16'($urandom_range(0, 4000)) - 16'sd2000;
      u_if.wz = 16'($urandom_range(0, 4000)) - 16'sd2000;
      u_if.dt = 16'($urandom);
      if (u_if.q_valid === 1'b1) begin
        if (p1 < 0)      p1 = c;
        else if (p2 < 0) p2 = c;
      end
    end
    chk("throughput", p2 - p1, BUSY + 1);
    @(negedge clk);
    u_if.s_valid = 1'b0;
    n = 0;
    while (u_if.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end

    // Reset mid-update.
    send(700, 100, -50, 6554);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid_reset");

    // Randomised samples with occasional clears.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        clear_q();
      end else begin
        send(int'(16'($urandom)) - ((($urandom & 1) == 1) ? 0 : 0) - 32768 + 32768 -
             ((int'(16'($urandom)) >= 32768) ? 0 : 0),
             $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
             $urandom_range(0, 65535));
        wait_qv("lat_random", QV);
      end
    end

    // Saturation of dq on the DT_SHIFT=8 instance.
    clear_q();
    send(32767, 0, 0, 65535);
    wait_qv("lat_sat_pos", QV);
`ifndef QUAT_RENORM_EN
    chk("sat_pos_q0", u_if8.q0, 32766);
    chk("sat_pos_q1", u_if8.q1, 32766);
`endif
    clear_q();
    send(-32768, 0, 0, 65535);
    wait_qv("lat_sat_neg", QV);
`ifndef QUAT_RENORM_EN
    chk("sat_neg_q1", u_if8.q1, -32767);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
